// File: rtl/group_enable_scheduler.sv
// ---------------------------------------------------------------------------
// group_enable_scheduler
//
// Round-robin scheduler for the per-group enable grid of one pixel-hierarchy
// level. It grants one requesting group at a time with a one-hot enable. It
// holds the grant until the group signals release or the watchdog expires.
// One mandatory RELEASE cycle with all enables low separates two grants.
//
// Ports:
//   clk_i          clock
//   reset_i        synchronous active-low reset
//   grp_req_i      per-group aggregated request, group g = row*GRP_COLS+col
//   grp_release_i  enabled group has finished (acted on only in HOLD)
//   active_i       enabled group still servicing events (informational)
//   halt_i         inhibit new grants (sampled only in IDLE)
//   enable_o       one-hot group enable, or all-zero
//   grp_enable_o   level-wide enable, high while a grant is held
//   grp_x_o        column of the granted group
//   grp_y_o        row of the granted group
//   busy_o         FSM not in IDLE
//   timeout_o      one-cycle pulse when the watchdog forces a release
// ---------------------------------------------------------------------------
module group_enable_scheduler #(
    parameter int GRP_ROWS = 4,
    parameter int GRP_COLS = 4,
    parameter int TIMEOUT  = 255,
    parameter int TO_W     = 8,
    localparam int X_W     = (GRP_COLS > 1) ? $clog2(GRP_COLS) : 1,
    localparam int Y_W     = (GRP_ROWS > 1) ? $clog2(GRP_ROWS) : 1
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [GRP_ROWS-1:0][GRP_COLS-1:0]  grp_req_i,
    input  logic                               grp_release_i,
    input  logic                               active_i,
    input  logic                               halt_i,
    output logic [GRP_ROWS-1:0][GRP_COLS-1:0]  enable_o,
    output logic                               grp_enable_o,
    output logic [X_W-1:0]                     grp_x_o,
    output logic [Y_W-1:0]                     grp_y_o,
    output logic                               busy_o,
    output logic                               timeout_o
);

    localparam int N     = GRP_ROWS * GRP_COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HOLD    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [TO_W-1:0]  counter;
    logic [N-1:0]     enable_q;
    logic [X_W-1:0]   grp_x_q;
    logic [Y_W-1:0]   grp_y_q;
    logic             timeout_q;

    logic [N-1:0]     req_flat;
    logic             found;
    logic [IDX_W-1:0] pick;
    logic [N-1:0]     pick_onehot;

    // active_i carries no control meaning here; it is kept on the port list
    // so the level can be wired uniformly.
    logic unused_inputs;
    assign unused_inputs = active_i;

    // Packed [row][col] flattens so that bit g = row*GRP_COLS+col.
    assign req_flat = grp_req_i;

    // Winner search: first set request at or above rr_ptr, wrapping N-1 -> 0.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] idx_c;
        found       = 1'b0;
        pick        = '0;
        pick_onehot = '0;
        idx         = 0;
        idx_c       = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_c = IDX_W'(idx);
            if (!found && req_flat[idx_c]) begin
                found = 1'b1;
                pick  = idx_c;
            end
        end
        pick_onehot[pick] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous; every register here is a plain flop, no memories.
        if (!reset_i) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            winner    <= '0;
            counter   <= '0;
            enable_q  <= '0;
            grp_x_q   <= '0;
            grp_y_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!halt_i && found) begin
                        winner   <= pick;
                        enable_q <= pick_onehot;
                        grp_x_q  <= X_W'(int'(pick) % GRP_COLS);
                        grp_y_q  <= Y_W'(int'(pick) / GRP_COLS);
                        counter  <= '0;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Release outranks the watchdog when both land together.
                    if (grp_release_i) begin
                        enable_q <= '0;
                        state    <= S_RELEASE;
                    end else if (counter == TO_W'(TIMEOUT - 1)) begin
                        enable_q  <= '0;
                        timeout_q <= 1'b1;
                        state     <= S_RELEASE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                S_RELEASE: begin
                    // Advance past the last winner so every requester gets a turn.
                    rr_ptr  <= (winner == IDX_W'(N - 1)) ? '0 : winner + 1'b1;
                    counter <= '0;
                    state   <= S_IDLE;
                end
                default: begin
                    enable_q <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    assign enable_o     = enable_q;
    assign grp_enable_o = |enable_q;
    assign grp_x_o      = grp_x_q;
    assign grp_y_o      = grp_y_q;
    assign busy_o       = (state != S_IDLE);
    assign timeout_o    = timeout_q;

endmodule
